// File: rtl/key_scan.sv
// 4x4 matrix keypad scanner: rotates an active-low row strobe on a divided tick,
// debounces press and release, and keeps a history of the last eight key codes.
module key_scan #(
  parameter int unsigned SCAN_DIV  = 25000,
  parameter int unsigned DEB_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [31:0] Data
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DebW = (DEB_TICKS > 0) ? $clog2(DEB_TICKS + 1) : 1;
  localparam logic [DivW-1:0] DivMax   = DivW'(SCAN_DIV - 1);
  localparam logic [DebW-1:0] DebTicks = DebW'(DEB_TICKS);

  typedef enum logic [1:0] {StScan, StDebounce, StPressed, StRelease} state_e;

  function automatic logic is_one_low(input logic [3:0] v);
    logic res;
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] res;
    if (!v[0])      res = 2'd0;
    else if (!v[1]) res = 2'd1;
    else if (!v[2]) res = 2'd2;
    else            res = 2'd3;
    return res;
  endfunction

  logic [3:0]      col_meta, col_s;
  logic [DivW-1:0] div_q, div_d;
  logic            tick;
  state_e          state_q, state_d;
  logic [3:0]      row_q, row_d, row_next;
  logic [DebW-1:0] stable_q, stable_d, stable_inc;
  logic [1:0]      r_q, r_d, c_q, c_d;
  logic [3:0]      col_lat_q, col_lat_d;
  logic            valid_q, valid_d;
  logic [3:0]      code_q, code_d;
  logic [31:0]     data_q, data_d;

  // The column lines are asynchronous; only col_s is used downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta <= 4'hF;
      col_s    <= 4'hF;
    end else begin
      col_meta <= col;
      col_s    <= col_meta;
    end
  end

  assign tick       = (div_q == DivMax);
  assign div_d      = tick ? '0 : div_q + 1'b1;
  assign row_next   = {row_q[2:0], row_q[3]};
  assign stable_inc = stable_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    stable_d  = stable_q;
    r_d       = r_q;
    c_d       = c_q;
    col_lat_d = col_lat_q;
    valid_d   = 1'b0;
    code_d    = code_q;
    data_d    = data_q;
    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (is_one_low(col_s)) begin
            r_d       = low_idx(row_q);
            c_d       = low_idx(col_s);
            col_lat_d = col_s;
            stable_d  = '0;
            state_d   = StDebounce;
          end else begin
            row_d = row_next;
          end
        end
        StDebounce: begin
          if (col_s == col_lat_q) begin
            stable_d = stable_inc;
            if (stable_inc == DebTicks) begin
              state_d = StPressed;
              valid_d = 1'b1;
              code_d  = {r_q, c_q};
              data_d  = {data_q[27:0], r_q, c_q};
            end
          end else begin
            state_d = StScan;
            row_d   = row_next;
          end
        end
        StPressed: begin
          if (col_s == 4'hF) begin
            stable_d = '0;
            state_d  = StRelease;
          end
        end
        StRelease: begin
          if (col_s == 4'hF) begin
            stable_d = stable_inc;
            if (stable_inc == DebTicks) begin
              state_d = StScan;
              row_d   = row_next;
            end
          end else begin
            // Bounce during release: keep holding, never re-emit.
            stable_d = '0;
            state_d  = StPressed;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      state_q   <= StScan;
      row_q     <= 4'b1110;
      stable_q  <= '0;
      r_q       <= 2'd0;
      c_q       <= 2'd0;
      col_lat_q <= 4'hF;
      valid_q   <= 1'b0;
      code_q    <= 4'h0;
      data_q    <= 32'h0;
    end else begin
      div_q     <= div_d;
      state_q   <= state_d;
      row_q     <= row_d;
      stable_q  <= stable_d;
      r_q       <= r_d;
      c_q       <= c_d;
      col_lat_q <= col_lat_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      data_q    <= data_d;
    end
  end

  assign row       = row_q;
  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign Data      = data_q;

endmodule

// File: tb/tb_key_scan.sv
// Keypad scanner bench: a key-matrix model drives col from row; expected key
// events are queued by the stimulus and checked whenever key_valid pulses.
module tb_key_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [31:0] Data;

  logic [15:0] keys = '0;
  logic [31:0] model_data = '0;
  logic [3:0]  exp_code_q[$];
  logic [31:0] exp_data_q[$];
  int          checks = 0;
  int          errors = 0;

  key_scan #(
    .SCAN_DIV  (4),
    .DEB_TICKS (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .key_valid (key_valid),
    .key_code  (key_code),
    .Data      (Data)
  );

  always #5 clk = ~clk;

  // Key (r,c) pulls column c low while row r is strobed.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !row[r]) col[c] = 1'b0;
  end

  always @(negedge clk) begin
    checks++;
    if ($countones(~row) != 1) begin
      errors++;
      $display("FAIL row_onehot: got %b, expected exactly one low bit", row);
    end
    if (!rst && key_valid) begin
      if (exp_code_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got key_valid with code %h, expected none", key_code);
      end else begin
        logic [3:0]  ec;
        logic [31:0] ed;
        ec = exp_code_q.pop_front();
        ed = exp_data_q.pop_front();
        checks++;
        if (key_code !== ec) begin
          errors++;
          $display("FAIL key_code: got %h, expected %h", key_code, ec);
        end
        checks++;
        if (Data !== ed) begin
          errors++;
          $display("FAIL Data: got %h, expected %h", Data, ed);
        end
      end
    end
  end

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string name);
    check_val({name, "_row"}, {28'h0, row}, 32'h0000_000E);
    check_val({name, "_valid"}, {31'h0, key_valid}, 32'h0);
    check_val({name, "_code"}, {28'h0, key_code}, 32'h0);
    check_val({name, "_data"}, Data, 32'h0);
  endtask

  // Returns right at the deassert edge so row-phase checks can start counting.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    model_data = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset_hold");
    rst = 1'b0;
  endtask

  task automatic check_rows(input int n);
    logic [3:0] exp;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      exp = ~(4'b0001 << ((i / 4) % 4));
      checks++;
      if (row !== exp) begin
        errors++;
        $display("FAIL row_scan[%0d]: got %b, expected %b", i, row, exp);
      end
    end
  endtask

  task automatic expect_key(input logic [3:0] code);
    model_data = {model_data[27:0], code};
    exp_code_q.push_back(code);
    exp_data_q.push_back(model_data);
  endtask

  task automatic press(input int code, input int hold, input int gap);
    expect_key(code[3:0]);
    keys[code] = 1'b1;
    repeat (hold) @(negedge clk);
    keys[code] = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");

    // Idle scanning.
    rst = 1'b0;
    check_rows(64);
    check_val("idle_data", Data, 32'h0);

    // Reset while debouncing key (0,0): no pulse, scan restarts at 1110.
    apply_reset();
    keys[0] = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    model_data = '0;
    @(negedge clk);
    check_reset_vals("reset_in_debounce");
    keys[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_rows(16);

    // One-tick glitch on (0,0), then a steady press.
    apply_reset();
    keys[0] = 1'b1;
    repeat (5) @(negedge clk);
    keys[0] = 1'b0;
    repeat (8) @(negedge clk);
    press(0, 60, 40);

    // Long hold of (1,2): one pulse only.
    press(6, 100, 40);
    check_val("hold_data", Data, 32'h0000_0006);
    check_val("hold_code", {28'h0, key_code}, 32'h6);

    // Hold (3,0), add (3,3), release both; then (3,3) alone.
    expect_key(4'hC);
    keys[12] = 1'b1;
    repeat (50) @(negedge clk);
    keys[15] = 1'b1;
    repeat (30) @(negedge clk);
    keys[12] = 1'b0;
    keys[15] = 1'b0;
    repeat (40) @(negedge clk);
    press(15, 60, 40);
    check_val("second_key_code", {28'h0, key_code}, 32'hF);

    // Nine presses overflow the eight-nibble history.
    apply_reset();
    for (int k = 1; k <= 9; k++) press(k, 60, 40);
    check_val("history_data", Data, 32'h2345_6789);
    check_val("history_code", {28'h0, key_code}, 32'h9);

    repeat (20) @(negedge clk);
    checks++;
    if (exp_code_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: got %0d outstanding, expected 0", exp_code_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_scan.md
KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 The block SHALL expose parameter SCAN_DIV, default 25000, meaning clk cycles per scan tick.
REQ-002 The block SHALL expose parameter DEB_TICKS, default 4, meaning consecutive stable ticks required for press/release acceptance.
REQ-003 The block SHALL have port clk  input  1  system clock; single clock domain, all state on posedge clk.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port col  input  4  keypad column lines, active-low, pulled up, asynchronous to clk.
REQ-006 The block SHALL have port row  output  4  keypad row drive, active-low one-hot.
REQ-007 The block SHALL have port key_valid  output  1  one-cycle pulse per accepted key press.
REQ-008 The block SHALL have port key_code  output  4  hex code of last accepted key.
REQ-009 The block SHALL have port Data  output  32  last eight accepted key codes, newest in Data[3:0], for display by the 7-segment driver.

Function
REQ-010 col SHALL pass through a 2-flop synchronizer (col_s); all decisions use col_s only.
REQ-011 A tick counter SHALL count 0..SCAN_DIV-1 and wrap; tick is high exactly one cycle, when the count equals SCAN_DIV-1.
REQ-012 The FSM SHALL have states SCAN, DEBOUNCE, PRESSED, RELEASE; state changes, row changes and stable-count changes occur only on tick cycles, except reset.
REQ-013 In SCAN, on each tick with col_s == 4'b1111 or col_s not one-hot-low, row SHALL rotate 1110->1101->1011->0111->1110.
REQ-014 In SCAN, on a tick with col_s one-hot-low, the FSM SHALL latch row index r (0..3, bit position of the low row bit) and column index c (bit position of the low col_s bit), hold row, clear the stable count, and go to DEBOUNCE.
REQ-015 In DEBOUNCE, each tick with col_s equal to the latched value SHALL increment the stable count; any other col_s SHALL return to SCAN, with row advancing to the next row on that tick.
REQ-016 When the stable count reaches DEB_TICKS, the FSM SHALL go to PRESSED and, on that same clk edge, assert key_valid, set key_code = 4*r + c, and set Data = {Data[27:0], key_code_new}.
REQ-017 key_valid SHALL be high for exactly one clk cycle per accepted press; holding a key SHALL never generate a repeat.
REQ-018 In PRESSED, row SHALL stay held; on the first tick with col_s == 4'b1111 the FSM SHALL clear the stable count and go to RELEASE.
REQ-019 In RELEASE, each tick with col_s == 4'b1111 SHALL increment the stable count; any tick with col_s != 4'b1111 SHALL return to PRESSED without emitting key_valid.
REQ-020 When the RELEASE stable count reaches DEB_TICKS, the FSM SHALL return to SCAN, with row advancing to the next row.
REQ-021 Pressing a second key while one is held SHALL be ignored until full release per REQ-020.
REQ-022 row SHALL always be exactly one-hot-low, in every state and cycle after reset.
REQ-023 key_code and Data SHALL change only on the key_valid cycle.
REQ-024 Data SHALL discard the oldest nibble (bits 31:28) on each shift, with no saturation.
REQ-025 Worst-case press latency from a stable col change SHALL be at most 2 clk (sync) + 4*SCAN_DIV + DEB_TICKS*SCAN_DIV cycles.

Reset
REQ-026 While rst is high, the block SHALL hold row=4'b1110, key_valid=0, key_code=4'h0, Data=32'h0, state=SCAN, tick and stable counters=0, and sync flops=4'b1111.
REQ-027 rst assertion mid-operation SHALL immediately abort any state without emitting key_valid.
REQ-028 After rst deasserts, scanning SHALL resume from row 1110 with the tick count at 0.

Verification (SCAN_DIV=4, DEB_TICKS=3)
REQ-029 No key pressed for 64 cycles -> row cycles 1110,1101,1011,0111 every 4 clk; key_valid never high; Data=0.
REQ-030 Key r=1,c=2 held 100 cycles then released -> exactly one key_valid pulse; key_code=4'h6; Data=32'h0000_0006.
REQ-031 Press sequence codes 1,2,...,9, each with full release -> Data=32'h2345_6789; the first nibble has been shifted out.
REQ-032 Bounce: key r=0,c=0 low for 1 tick, high, then low steady -> no pulse from the glitch; a single pulse with key_code=4'h0 after the steady debounce.
REQ-033 Key held, second key r=3,c=3 added, then both released -> one pulse only; a later separate press of r=3,c=3 gives key_code=4'hF.
REQ-034 rst asserted in DEBOUNCE state -> outputs equal reset values on the next sample; no key_valid; scanning restarts at 1110.
